h1_channel_scheduler: RTL and testbench

Time-multiplexes one H1 loop-filter tap computation across NCH independent delta-sigma channels. Each channel keeps its own two-sample history, so the channels share the arithmetic without sharing filter state. The block arbitrates per-channel sample requests round-robin, computes the H1 output for the granted channel, updates that channel's history, and presents the result with its channel id on a valid/ready output. It sits between the per-channel sample sources and the downstream quantizer/comparator stage.

---
 rtl/h1_pkg.sv | 32 +++
 rtl/h1_tap_alu.sv | 30 +++
 rtl/h1_channel_scheduler.sv | 177 +++++++++++++++++
 tb/tb_h1_channel_scheduler.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/h1_pkg.sv
// ---------------------------------------------------------------------------
// h1_pkg
// Shared definitions for the H1 channel scheduler.
//   W_DEFAULT : default sample/result width
//   h1_state_e: scheduler FSM encoding (IDLE / CALC / HOLD)
//   ch_width  : channel-id width for a power-of-two channel count
// ---------------------------------------------------------------------------
package h1_pkg;

  localparam int W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } h1_state_e;

  // Smallest w with 2**w >= n; exact log2 for the power-of-two counts used here.
  function automatic int ch_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) begin
        w = i + 1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/h1_tap_alu.sv
// ---------------------------------------------------------------------------
// h1_tap_alu
// Combinational H1 tap: y = (d1<<1) + (d1<<2) - (d2<<1) = 6*d1 - 2*d2.
// Every term is truncated to W bits and the sum wraps modulo 2**W.
// Ports:
//   d1 in  W  previous sample x[n-1]
//   d2 in  W  sample before that, x[n-2]
//   y  out W  filter tap result
// ---------------------------------------------------------------------------
module h1_tap_alu #(
  parameter int W = 16
) (
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic [W-1:0] y
);

  logic [W-1:0] d1_x2_s;
  logic [W-1:0] d1_x4_s;
  logic [W-1:0] d2_x2_s;

  // Shift-and-add datapath; shifted-out MSBs are dropped on purpose.
  always_comb begin
    d1_x2_s = {d1[W-2:0], 1'b0};
    d1_x4_s = {d1[W-3:0], 2'b00};
    d2_x2_s = {d2[W-2:0], 1'b0};
    y       = d1_x2_s + d1_x4_s - d2_x2_s;
  end

endmodule

// File: rtl/h1_channel_scheduler.sv
// ---------------------------------------------------------------------------
// h1_channel_scheduler
// Shares one H1 tap ALU across NCH channels. Requests are granted
// round-robin, the granted channel's result is computed from its own
// two-sample history, and the result is offered on a valid/ready port.
// Ports:
//   CLK       in  1      clock, rising edge
//   reset     in  1      synchronous active-low reset
//   in_valid  in  NCH    per-channel sample request
//   in_data   in  NCH*W  channel c sample at [c*W +: W]
//   in_ready  out NCH    one-hot grant (IDLE only)
//   hist_clr  in  1      synchronous clear of every channel history
//   out_valid out 1      result available
//   out_data  out W      H1 result
//   out_ch    out CW     channel id of out_data
//   out_ready in  1      downstream accepts result (HOLD only)
// ---------------------------------------------------------------------------
module h1_channel_scheduler
  import h1_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = W_DEFAULT,
  localparam int CW = ch_width(NCH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [NCH-1:0]   in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic [NCH-1:0]   in_ready,
  input  logic             hist_clr,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  input  logic             out_ready
);

  h1_state_e      state_q, state_d;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [W-1:0]   x_q, x_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]  out_ch_q, out_ch_d;
  logic [W-1:0]   d1_q [NCH];
  logic [W-1:0]   d1_d [NCH];
  logic [W-1:0]   d2_q [NCH];
  logic [W-1:0]   d2_d [NCH];

  logic           grant_found_s;
  logic [CW-1:0]  grant_ch_s;
  logic [CW-1:0]  cand_s;
  logic [NCH-1:0] in_ready_s;
  logic [W-1:0]   alu_y_s;

  // Shared tap arithmetic, always looking at the captured channel's history.
  h1_tap_alu #(.W(W)) u_alu (
    .d1 (d1_q[ch_q]),
    .d2 (d2_q[ch_q]),
    .y  (alu_y_s)
  );

  // Round-robin picker: first requester at or after rr_ptr, wrapping mod NCH.
  always_comb begin
    grant_found_s = 1'b0;
    grant_ch_s    = {CW{1'b0}};
    cand_s        = {CW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      cand_s        = rr_ptr_q + CW'(i);
      grant_ch_s    = (!grant_found_s && in_valid[cand_s]) ? cand_s : grant_ch_s;
      grant_found_s = grant_found_s | in_valid[cand_s];
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {CW{1'b0}};
      ch_q        <= {CW{1'b0}};
      x_q         <= {W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {W{1'b0}};
      out_ch_q    <= {CW{1'b0}};
      for (int c = 0; c < NCH; c++) begin
        d1_q[c] <= {W{1'b0}};
        d2_q[c] <= {W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      ch_q        <= ch_d;
      x_q         <= x_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      for (int c = 0; c < NCH; c++) begin
        d1_q[c] <= d1_d[c];
        d2_q[c] <= d2_d[c];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = grant_found_s ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = ST_HOLD;
      ST_HOLD: state_d = out_ready ? ST_IDLE : ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-state outputs, capture, result register and history update.
  always_comb begin
    in_ready_s  = {NCH{1'b0}};
    rr_ptr_d    = rr_ptr_q;
    ch_d        = ch_q;
    x_d         = x_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    for (int c = 0; c < NCH; c++) begin
      d1_d[c] = d1_q[c];
      d2_d[c] = d2_q[c];
    end
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          in_ready_s[grant_ch_s] = 1'b1;
          x_d  = in_data[int'(grant_ch_s)*W +: W];
          ch_d = grant_ch_s;
        end else begin
          in_ready_s = {NCH{1'b0}};
        end
      end
      ST_CALC: begin
        // Result uses the history as it stood before this edge.
        out_data_d  = alu_y_s;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        d2_d[ch_q]  = d1_q[ch_q];
        d1_d[ch_q]  = x_q;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rr_ptr_d    = ch_q + CW'(1'b1);
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        in_ready_s = {NCH{1'b0}};
      end
    endcase
    // A clear wins over the CALC history update but not over the result.
    if (hist_clr) begin
      for (int c = 0; c < NCH; c++) begin
        d1_d[c] = {W{1'b0}};
        d2_d[c] = {W{1'b0}};
      end
    end else begin
      ch_d = ch_d;
    end
  end

  // Grants are suppressed while reset is asserted.
  always_comb begin
    in_ready = reset ? in_ready_s : {NCH{1'b0}};
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_h1_channel_scheduler.sv
module tb_h1_channel_scheduler;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CW  = 2;

  logic             CLK;
  logic             reset;
  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
  logic             hist_clr;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_ch;
  logic             out_ready;

  int n_checks;
  int n_fail;

  h1_channel_scheduler #(.NCH(NCH), .W(W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .hist_clr  (hist_clr),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample on channel ch. Called just after a falling edge; returns just
  // after the falling edge that follows the output handshake. 'others' are
  // extra requests raised once this sample has been accepted.
  task automatic xact(input string tag, input int ch, input logic [W-1:0] x,
                      input logic [NCH-1:0] others, input logic [W-1:0] exp_y,
                      input int hold_cycles, input bit clr_in_calc);
    int n;
    logic [NCH-1:0] onehot;
    onehot = NCH'(1) << ch;
    in_data[ch*W +: W] = x;
    in_valid  = onehot;
    out_ready = (hold_cycles == 0);
    n = 0;
    #1;
    while (in_ready[ch] !== 1'b1 && n < 30) begin
      @(negedge CLK); #1;
      n++;
    end
    check_eq({tag, "_grant"}, 32'(in_ready), 32'(onehot));
    @(negedge CLK);
    in_valid = others;
    hist_clr = clr_in_calc;
    #1;
    check_eq({tag, "_calc_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_calc_ready"}, 32'(in_ready), 32'd0);
    @(negedge CLK);
    hist_clr = 1'b0;
    #1;
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp_y));
    check_eq({tag, "_ch"}, 32'(out_ch), 32'(ch));
    for (int i = 0; i < hold_cycles; i++) begin
      @(negedge CLK); #1;
      check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_data"}, 32'(out_data), 32'(exp_y));
      check_eq({tag, "_hold_ch"}, 32'(out_ch), 32'(ch));
      check_eq({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge CLK); #1;
    check_eq({tag, "_done"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b0;
    in_valid  = {NCH{1'b1}};
    in_data   = {NCH*W{1'b0}};
    hist_clr  = 1'b0;
    out_ready = 1'b0;

    // Reset: outputs cleared, grants blocked even with all requests high.
    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_ch", 32'(out_ch), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    @(negedge CLK);
    reset    = 1'b1;
    in_valid = {NCH{1'b0}};

    // Channel 0: 1,1,1 -> 0, 6, 4.
    xact("t1a", 0, 16'd1, 4'b0000, 16'd0, 0, 1'b0);
    xact("t1b", 0, 16'd1, 4'b0000, 16'd6, 0, 1'b0);
    xact("t1c", 0, 16'd1, 4'b0000, 16'd4, 0, 1'b0);

    // All channels at once after reset: grants 0,1,2,3, all results 0.
    reset = 1'b0;
    @(negedge CLK);
    reset    = 1'b1;
    in_valid = 4'hF;
    in_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    for (int g = 0; g < NCH; g++) begin
      #1;
      check_eq("t2_grant", 32'(in_ready), 32'd1 << g);
      check_eq("t2_onehot", 32'($countones(in_ready)), 32'd1);
      @(negedge CLK);
      in_valid[g] = 1'b0;
      #1;
      check_eq("t2_calc_ready", 32'(in_ready), 32'd0);
      @(negedge CLK); #1;
      check_eq("t2_valid", 32'(out_valid), 32'd1);
      check_eq("t2_data", 32'(out_data), 32'd0);
      check_eq("t2_ch", 32'(out_ch), 32'(g));
      @(negedge CLK);
    end

    // Clear histories from IDLE, then the wrap case on channel 1:
    // 0; 6*0x3000 = 0x12000 -> 0x2000; 6*0x3000 - 2*0x3000 = 0xC000.
    hist_clr = 1'b1;
    @(negedge CLK);
    hist_clr = 1'b0;
    xact("t3a", 1, 16'h3000, 4'b0000, 16'h0000, 0, 1'b0);
    xact("t3b", 1, 16'h3000, 4'b0000, 16'h2000, 0, 1'b0);
    xact("t3c", 1, 16'h0000, 4'b0000, 16'hC000, 0, 1'b0);

    // Back-pressure on channel 3 (5 then 9 -> 30) with others requesting.
    xact("t4a", 3, 16'd5, 4'b0000, 16'd0, 0, 1'b0);
    xact("t4b", 3, 16'd9, 4'b0111, 16'd30, 5, 1'b0);
    check_eq("t4_rr_next", 32'(in_ready), 32'd1);
    xact("t4c", 0, 16'd3, 4'b0000, 16'd0, 0, 1'b0);

    // hist_clr in CALC on channel 2 after 5, 7: result 32, later ones 0.
    xact("t5a", 2, 16'd5, 4'b0000, 16'd0, 0, 1'b0);
    xact("t5b", 2, 16'd7, 4'b0000, 16'd30, 0, 1'b0);
    xact("t5c", 2, 16'd9, 4'b0000, 16'd32, 0, 1'b1);
    xact("t5d", 2, 16'd1, 4'b0000, 16'd0, 0, 1'b0);
    xact("t5e", 0, 16'd3, 4'b0000, 16'd0, 0, 1'b0);

    // Reset during HOLD: channel 0 result 18 dropped, history cleared.
    in_data[0 +: W] = 16'd4;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    #1;
    check_eq("t6_grant", 32'(in_ready), 32'd1);
    @(negedge CLK);
    in_valid = 4'b0000;
    @(negedge CLK); #1;
    check_eq("t6_valid", 32'(out_valid), 32'd1);
    check_eq("t6_data", 32'(out_data), 32'd18);
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_data", 32'(out_data), 32'd0);
    check_eq("t6_rst_ch", 32'(out_ch), 32'd0);
    xact("t6b", 0, 16'd2, 4'b0000, 16'd0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
